ap_ctrl_driver: RTL and testbench
=================================

# ap_ctrl_driver

Synthesizable driver for the HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue) of a generated kernel such as the RV32I core IP. It issues a programmed number of start transactions, applies configurable inter-start gaps and ap_continue back-pressure, and timestamps every transaction to report latency and completion count. It raises the `finish` level that the dataflow monitors consume. It sits between the testbench/host sequencer and the kernel's control port.

## Interface
Parameters:
- TXN_W, 16, width of transaction counts
- CYC_W, 32, width of the free-running cycle counter and latency values
- MAX_OUT, 4, maximum outstanding (started, not completed) transactions; power of two

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- go  in  1  one-cycle launch request; accepted only in IDLE
- cfg_num_txn  in  TXN_W  transactions to run; sampled on accepted go
- cfg_gap  in  8  idle cycles between a start acceptance and the next ap_start assertion; sampled on go
- cfg_cont_dly  in  8  cycles ap_continue is withheld after ap_done rises; 0 = continue tied high; sampled on go
- ap_start  out  1  kernel start request
- ap_ready  in  1  kernel accepted the start
- ap_done  in  1  kernel finished one transaction; held until ap_continue
- ap_continue  out  1  permits the kernel to retire ap_done
- busy  out  1  high from accepted go until finish
- finish  out  1  level, high once all transactions have completed; cleared by the next accepted go
- txn_started  out  TXN_W  starts accepted this run
- txn_done  out  TXN_W  completions this run
- last_lat  out  CYC_W  latency of the most recent completion
- max_lat  out  CYC_W  maximum latency this run
- err_done  out  1  sticky; ap_done completed with no outstanding transaction

## Operation
- States: IDLE, START, GAP, DRAIN, DONE.
- IDLE: on go, latch the cfg values, clear counters/latencies/err_done, and drop finish. With cfg_num_txn = 0, go to DONE; otherwise go to START.
- START: ap_start high while fewer than MAX_OUT transactions are outstanding.
  - Acceptance is ap_start && ap_ready. It pushes the current cycle count into the timestamp FIFO and increments txn_started.
  - After acceptance, if txn_started reaches cfg_num_txn, go to DRAIN. Otherwise go to GAP if cfg_gap > 0, else stay in START.
- GAP: ap_start low; count cfg_gap cycles, then return to START.
- DRAIN: ap_start low; when txn_done reaches cfg_num_txn, go to DONE.
- DONE: finish high, busy low. Return to IDLE in the same cycle (finish stays high).
- Completion is ap_done && ap_continue. It pops the timestamp FIFO and sets last_lat = cycle_cnt − popped stamp. It updates max_lat if larger and increments txn_done.
- Completion is processed in every state except IDLE.
- ap_continue:
  - cfg_cont_dly = 0: high whenever busy.
  - Otherwise: a counter starts on the first cycle ap_done is high with no continue pending. ap_continue is asserted for exactly one cycle when the counter reaches cfg_cont_dly.
- Completion with an empty FIFO: set err_done, do not count it, do not change the latencies.
- Widths: cycle_cnt wraps modulo 2^CYC_W, and the latency subtraction is modulo the same. Counters do not wrap within a run because cfg_num_txn bounds them.

## Timing
- Reset values: ap_start 0, ap_continue 0, busy 0, finish 0, all counters/latencies 0, err_done 0, state IDLE, FIFO empty.
- Reset is asynchronous. Assertion mid-run aborts immediately to reset values, with no further handshake activity.
- ap_start rises the cycle after go is accepted. Once asserted, it is held until ap_ready is sampled high; it is never withdrawn early.
- Back-to-back starts (cfg_gap = 0, ap_ready always high): one acceptance per cycle until MAX_OUT outstanding.
- FIFO full: ap_start is held low (not asserted) until a completion frees a slot. A completion and an acceptance in the same cycle are both legal.
- Latency counts from the acceptance edge to the completion edge. Combinational ready/done in the same cycle as acceptance gives latency 0.
- finish rises one cycle after the completing edge. go is ignored while busy.

## Structure
- Shared package `ap_ctrl_pkg`: state enum, default widths, MAX_OUT.
- Sub-module `ts_fifo`: a synchronous FIFO of depth MAX_OUT and width CYC_W. It provides push/pop/full/empty and supports simultaneous push+pop when full or empty.

## Test plan
- num_txn=3, gap=0, cont_dly=0; kernel latency 5, ready on start → three starts on consecutive cycles; last_lat=max_lat=5; txn_done=3; finish high.
- num_txn=2, gap=4 → second ap_start rises exactly 5 cycles after the first acceptance.
- num_txn=8, MAX_OUT=4, kernel latency 20 → ap_start low after 4 outstanding and resumes on the first completion; all 8 latencies equal 20.
- cont_dly=3, ap_done held → ap_continue pulses one cycle, 3 cycles after ap_done rises; latency includes the 3-cycle stall.
- Spurious ap_done with nothing outstanding → err_done=1; txn_done unchanged.
- reset low mid-DRAIN → all outputs at reset values immediately; a new go runs cleanly with counters restarted from 0.

Source files
------------

// File: rtl/ap_ctrl_pkg.sv
// Shared constants for the ap_ctrl handshake driver: default widths and FSM encodings.
package ap_ctrl_pkg;

    localparam int DEF_TXN_W   = 16;
    localparam int DEF_CYC_W   = 32;
    localparam int DEF_MAX_OUT = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/ap_ctrl_driver_ts_fifo.sv
// Start-timestamp FIFO; a push and a pop on an empty FIFO pass the pushed word straight through.
module ts_fifo
    import ap_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUT,
    parameter int W     = DEF_CYC_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          bypass, wr, rd;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign bypass   = empty && push && pop;
    assign wr       = push && !bypass && (!full || pop);
    assign rd       = pop && !empty;
    assign pop_data = empty ? push_data : mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Block-level ap_ctrl handshake driver: issues paced start transactions, throttles
// ap_continue, and records completion count and per-transaction latency.
module ap_ctrl_driver
    import ap_ctrl_pkg::*;
#(
    parameter int TXN_W   = DEF_TXN_W,
    parameter int CYC_W   = DEF_CYC_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic [7:0]       cfg_gap,
    input  logic [7:0]       cfg_cont_dly,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [TXN_W-1:0] txn_started,
    output logic [TXN_W-1:0] txn_done,
    output logic [CYC_W-1:0] last_lat,
    output logic [CYC_W-1:0] max_lat,
    output logic             err_done
);

    state_t             state_q, state_d;
    logic [TXN_W-1:0]   num_q, num_d, started_q, started_d, done_q, done_d;
    logic [7:0]         gap_q, gap_d, dly_q, dly_d, gap_cnt_q, gap_cnt_d, cont_cnt_q, cont_cnt_d;
    logic [CYC_W-1:0]   cyc_q, last_q, last_d, max_q, max_d, stamp, lat;
    logic               err_q, err_d, finish_q, finish_d, pend_q, pend_d;
    logic               active, accept, complete, orphan, fifo_full, fifo_empty;

    assign active      = (state_q != ST_IDLE);
    assign busy        = (state_q == ST_START) || (state_q == ST_GAP) || (state_q == ST_DRAIN);
    assign ap_start    = (state_q == ST_START) && !fifo_full;
    assign accept      = ap_start && ap_ready;
    assign ap_continue = (dly_q == 8'd0) ? busy : (active && pend_q && (cont_cnt_q == dly_q));
    assign complete    = ap_done && ap_continue;
    assign orphan      = fifo_empty && !accept;
    assign lat         = cyc_q - stamp;

    assign finish      = finish_q;
    assign txn_started = started_q;
    assign txn_done    = done_q;
    assign last_lat    = last_q;
    assign max_lat     = max_q;
    assign err_done    = err_q;

    ts_fifo #(.DEPTH(MAX_OUT), .W(CYC_W)) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (cyc_q),
        .pop       (complete),
        .pop_data  (stamp),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        gap_d      = gap_q;
        dly_d      = dly_q;
        gap_cnt_d  = gap_cnt_q;
        started_d  = started_q;
        done_d     = done_q;
        last_d     = last_q;
        max_d      = max_q;
        err_d      = err_q;
        finish_d   = finish_q;
        pend_d     = pend_q;
        cont_cnt_d = cont_cnt_q;

        case (state_q)
            ST_IDLE: if (go) begin
                num_d      = cfg_num_txn;
                gap_d      = cfg_gap;
                dly_d      = cfg_cont_dly;
                started_d  = '0;
                done_d     = '0;
                last_d     = '0;
                max_d      = '0;
                err_d      = 1'b0;
                pend_d     = 1'b0;
                cont_cnt_d = 8'd0;
                finish_d   = (cfg_num_txn == '0);
                state_d    = (cfg_num_txn == '0) ? ST_DONE : ST_START;
            end
            ST_START: if (accept) begin
                started_d = started_q + TXN_W'(1);
                gap_cnt_d = 8'd0;
                if (started_d == num_q)  state_d = ST_DRAIN;
                else if (gap_q != 8'd0)  state_d = ST_GAP;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == gap_q - 8'd1) state_d = ST_START;
            end
            ST_DRAIN: if (done_q == num_q) begin
                state_d  = ST_DONE;
                finish_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion with no recorded start is flagged but never counted or timed.
        if (complete) begin
            if (orphan) begin
                err_d = 1'b1;
            end else begin
                done_d = done_q + TXN_W'(1);
                last_d = lat;
                if (lat > max_q) max_d = lat;
            end
        end

        if (active && dly_q != 8'd0) begin
            if (ap_continue)  pend_d = 1'b0;
            else if (pend_q)  cont_cnt_d = cont_cnt_q + 8'd1;
            else if (ap_done) begin
                pend_d     = 1'b1;
                cont_cnt_d = 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            gap_q      <= 8'd0;
            dly_q      <= 8'd0;
            gap_cnt_q  <= 8'd0;
            started_q  <= '0;
            done_q     <= '0;
            cyc_q      <= '0;
            last_q     <= '0;
            max_q      <= '0;
            err_q      <= 1'b0;
            finish_q   <= 1'b0;
            pend_q     <= 1'b0;
            cont_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            gap_q      <= gap_d;
            dly_q      <= dly_d;
            gap_cnt_q  <= gap_cnt_d;
            started_q  <= started_d;
            done_q     <= done_d;
            cyc_q      <= cyc_q + CYC_W'(1);
            last_q     <= last_d;
            max_q      <= max_d;
            err_q      <= err_d;
            finish_q   <= finish_d;
            pend_q     <= pend_d;
            cont_cnt_q <= cont_cnt_d;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver with a fixed-latency kernel model and a latency scoreboard.
module tb_ap_ctrl_driver;

    localparam int TXN_W = 16;
    localparam int CYC_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             go;
    logic [TXN_W-1:0] cfg_num_txn;
    logic [7:0]       cfg_gap, cfg_cont_dly;
    logic             ap_start, ap_ready, ap_done, ap_continue;
    logic             busy, finish, err_done;
    logic [TXN_W-1:0] txn_started, txn_done;
    logic [CYC_W-1:0] last_lat, max_lat;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int kq[$];
    int sb[$];
    int acc_log[$];
    int lat_cfg = 5;
    int chk_lat, ndone, done_rise, cont_cyc, cont_hi;
    bit spur = 1'b0, chk = 1'b0, chk_err = 1'b0, done_prev = 1'b0;

    ap_ctrl_driver #(.TXN_W(TXN_W), .CYC_W(CYC_W), .MAX_OUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .cfg_num_txn  (cfg_num_txn),
        .cfg_gap      (cfg_gap),
        .cfg_cont_dly (cfg_cont_dly),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .finish       (finish),
        .txn_started  (txn_started),
        .txn_done     (txn_done),
        .last_lat     (last_lat),
        .max_lat      (max_lat),
        .err_done     (err_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Kernel model: accepts every start, raises ap_done lat_cfg cycles later and holds it until retired.
    always @(negedge clock) begin
        if (!reset) begin
            kq.delete();
            sb.delete();
            ap_done   = 1'b0;
            chk       = 1'b0;
            chk_err   = 1'b0;
            spur      = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (chk) begin
                check("sb_last_lat", 64'(last_lat), 64'(chk_lat));
                check("sb_txn_done", 64'(txn_done), 64'(ndone));
                chk = 1'b0;
            end
            if (chk_err) begin
                check("spur_err_done", 64'(err_done), 64'd1);
                check("spur_txn_done", 64'(txn_done), 64'(ndone));
                chk_err = 1'b0;
            end
            #1;
            if (ap_start && ap_ready) begin
                kq.push_back(cyc + lat_cfg);
                sb.push_back(cyc);
                acc_log.push_back(cyc);
            end
            ap_done = spur || ((kq.size() > 0) ? (kq[0] <= cyc) : 1'b0);
            if (ap_done && !done_prev) done_rise = cyc;
            if (ap_continue) begin
                cont_hi++;
                cont_cyc = cyc;
            end
            if (ap_done && ap_continue) begin
                if (spur) begin
                    spur    = 1'b0;
                    chk_err = 1'b1;
                end else begin
                    void'(kq.pop_front());
                    chk_lat = cyc - sb.pop_front();
                    ndone++;
                    chk = 1'b1;
                end
            end
            done_prev = ap_done;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ap_start"}, 64'(ap_start), 64'd0);
        check({tag, "_ap_continue"}, 64'(ap_continue), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_finish"}, 64'(finish), 64'd0);
        check({tag, "_txn_started"}, 64'(txn_started), 64'd0);
        check({tag, "_txn_done"}, 64'(txn_done), 64'd0);
        check({tag, "_last_lat"}, 64'(last_lat), 64'd0);
        check({tag, "_max_lat"}, 64'(max_lat), 64'd0);
        check({tag, "_err_done"}, 64'(err_done), 64'd0);
    endtask

    task automatic start_run(input int n, input int g, input int d, input int l);
        @(negedge clock);
        lat_cfg = l;
        acc_log.delete();
        cont_hi = 0;
        ndone   = 0;
        go           = 1'b1;
        cfg_num_txn  = TXN_W'(n);
        cfg_gap      = 8'(g);
        cfg_cont_dly = 8'(d);
        @(negedge clock);
        go = 1'b0;
        check("start_rise", 64'(ap_start), 64'd1);
        check("busy_after_go", 64'(busy), 64'd1);
        check("finish_cleared", 64'(finish), 64'd0);
    endtask

    task automatic wait_finish(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clock);
            if (finish) break;
        end
        check("finish_reached", 64'(finish), 64'd1);
        check("busy_at_finish", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; go = 1'b0; ap_ready = 1'b1;
        cfg_num_txn = '0; cfg_gap = 8'd0; cfg_cont_dly = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b1;

        // Back-to-back starts, latency 5
        start_run(3, 0, 0, 5);
        wait_finish(100);
        check("t1_started", 64'(txn_started), 64'd3);
        check("t1_done", 64'(txn_done), 64'd3);
        check("t1_last_lat", 64'(last_lat), 64'd5);
        check("t1_max_lat", 64'(max_lat), 64'd5);
        check("t1_consec_a", 64'(acc_log[1] - acc_log[0]), 64'd1);
        check("t1_consec_b", 64'(acc_log[2] - acc_log[1]), 64'd1);
        check("t1_cont_idle", 64'(ap_continue), 64'd0);

        // Inter-start gap of 4
        start_run(2, 4, 0, 5);
        wait_finish(100);
        check("t2_gap_spacing", 64'(acc_log[1] - acc_log[0]), 64'd5);
        check("t2_done", 64'(txn_done), 64'd2);

        // Outstanding limit with long latency
        start_run(8, 0, 0, 20);
        wait_finish(300);
        check("t3_acc_count", 64'(acc_log.size()), 64'd8);
        check("t3_first_four", 64'(acc_log[3] - acc_log[0]), 64'd3);
        check("t3_resume", 64'(acc_log[4] - acc_log[0]), 64'd21);
        check("t3_done", 64'(txn_done), 64'd8);
        check("t3_last_lat", 64'(last_lat), 64'd20);
        check("t3_max_lat", 64'(max_lat), 64'd20);

        // Delayed ap_continue
        start_run(1, 0, 3, 5);
        wait_finish(100);
        check("t4_cont_pulses", 64'(cont_hi), 64'd1);
        check("t4_cont_delay", 64'(cont_cyc - done_rise), 64'd3);
        check("t4_last_lat", 64'(last_lat), 64'd8);
        check("t4_max_lat", 64'(max_lat), 64'd8);

        // Spurious ap_done while nothing is outstanding
        start_run(2, 20, 0, 3);
        repeat (8) @(negedge clock);
        spur = 1'b1;
        wait_finish(100);
        check("t5_err_sticky", 64'(err_done), 64'd1);
        check("t5_done", 64'(txn_done), 64'd2);
        check("t5_started", 64'(txn_started), 64'd2);
        check("t5_max_lat", 64'(max_lat), 64'd3);

        // Reset mid-drain, then a clean rerun
        start_run(4, 0, 0, 30);
        repeat (6) @(negedge clock);
        check("t6_started_pre", 64'(txn_started), 64'd4);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clock);
        reset = 1'b1;
        start_run(2, 0, 0, 5);
        wait_finish(100);
        check("t6_started", 64'(txn_started), 64'd2);
        check("t6_done", 64'(txn_done), 64'd2);
        check("t6_last_lat", 64'(last_lat), 64'd5);
        check("t6_max_lat", 64'(max_lat), 64'd5);
        check("t6_err", 64'(err_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
